// File: rtl/button_debounce_generic.sv
// Push-button conditioning: reset synchronizer, per-button two-flop sync and a
// counter-based debounce FSM producing press/release pulses and a held level.
//
// state        | meaning
// RELEASED     | debounced level released, waiting for a held sample
// PRESS_WAIT   | held seen, counting consecutive held samples
// PRESSED      | debounced level held, waiting for a released sample
// RELEASE_WAIT | released seen, counting consecutive released samples
module button_debounce_generic #(
  parameter int DEVICE_COUNT    = 3,
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic                    clock,
  input  logic                    reset_n,
  input  logic [DEVICE_COUNT-1:0] button_n,
  output logic                    reset_s2_n,
  output logic [DEVICE_COUNT-1:0] button_pressed,
  output logic [DEVICE_COUNT-1:0] button_released,
  output logic [DEVICE_COUNT-1:0] button_state
);

  localparam int              CNT_W    = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  localparam logic [1:0] ST_RELEASED     = 2'd0;
  localparam logic [1:0] ST_PRESS_WAIT   = 2'd1;
  localparam logic [1:0] ST_PRESSED      = 2'd2;
  localparam logic [1:0] ST_RELEASE_WAIT = 2'd3;

  logic                    reset_s1_n;
  logic [DEVICE_COUNT-1:0] btn_s1_n;
  logic [DEVICE_COUNT-1:0] btn_s2_n;
  logic [DEVICE_COUNT-1:0] btn_held;

  // Asserts asynchronously, releases on the second clock edge after reset_n rises.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      reset_s1_n <= 1'b0;
      reset_s2_n <= 1'b0;
    end else begin
      reset_s1_n <= 1'b1;
      reset_s2_n <= reset_s1_n;
    end
  end

  always_ff @(posedge clock or negedge reset_s2_n) begin
    if (!reset_s2_n) begin
      btn_s1_n <= '1;
      btn_s2_n <= '1;
    end else begin
      btn_s1_n <= button_n;
      btn_s2_n <= btn_s1_n;
    end
  end

  assign btn_held = ~btn_s2_n;

  for (genvar g = 0; g < DEVICE_COUNT; g++) begin : g_btn
    logic [1:0]       state;
    logic [CNT_W-1:0] cnt;
    logic             pressed_q;
    logic             released_q;
    logic             level_q;

    always_ff @(posedge clock or negedge reset_s2_n) begin
      if (!reset_s2_n) begin
        state      <= ST_RELEASED;
        cnt        <= '0;
        pressed_q  <= 1'b0;
        released_q <= 1'b0;
        level_q    <= 1'b0;
      end else begin
        pressed_q  <= 1'b0;
        released_q <= 1'b0;
        case (state)
          ST_RELEASED: begin
            if (btn_held[g]) begin
              state <= ST_PRESS_WAIT;
              cnt   <= '0;
            end
          end
          ST_PRESS_WAIT: begin
            if (!btn_held[g]) begin
              state <= ST_RELEASED;
              cnt   <= '0;
            end else if (cnt == CNT_LAST) begin
              state     <= ST_PRESSED;
              cnt       <= '0;
              pressed_q <= 1'b1;
              level_q   <= 1'b1;
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end
          ST_PRESSED: begin
            if (!btn_held[g]) begin
              state <= ST_RELEASE_WAIT;
              cnt   <= '0;
            end
          end
          ST_RELEASE_WAIT: begin
            if (btn_held[g]) begin
              state <= ST_PRESSED;
              cnt   <= '0;
            end else if (cnt == CNT_LAST) begin
              state      <= ST_RELEASED;
              cnt        <= '0;
              released_q <= 1'b1;
              level_q    <= 1'b0;
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end
          default: begin
            state <= ST_RELEASED;
            cnt   <= '0;
          end
        endcase
      end
    end

    assign button_pressed[g]  = pressed_q;
    assign button_released[g] = released_q;
    assign button_state[g]    = level_q;
  end

endmodule

// File: tb/tb_button_debounce_generic.sv
// Bench for button_debounce_generic: directed scenarios plus random button activity,
// all compared every cycle against a run-length debounce model.
module tb_button_debounce_generic;

  localparam int DC = 3;
  localparam int DB = 4;

  logic          clock = 1'b0;
  logic          reset_n = 1'b0;
  logic [DC-1:0] button_n = '1;
  logic          reset_s2_n;
  logic [DC-1:0] button_pressed;
  logic [DC-1:0] button_released;
  logic [DC-1:0] button_state;

  button_debounce_generic #(
    .DEVICE_COUNT   (DC),
    .DEBOUNCE_CYCLES(DB)
  ) dut (
    .clock          (clock),
    .reset_n        (reset_n),
    .button_n       (button_n),
    .reset_s2_n     (reset_s2_n),
    .button_pressed (button_pressed),
    .button_released(button_released),
    .button_state   (button_state)
  );

  always #5 clock = ~clock;

  int n_cmp = 0;
  int n_mis = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Model: a level is accepted after DB+1 consecutive synchronized samples that
  // differ from the accepted level; any agreeing sample restarts the run.
  int            m_rs;
  logic [DC-1:0] m_s1, m_s2, m_acc, m_pr, m_rl;
  int            m_run [DC];

  task automatic model_reset();
    m_rs  = 0;
    m_s1  = '0;
    m_s2  = '0;
    m_acc = '0;
    m_pr  = '0;
    m_rl  = '0;
    for (int i = 0; i < DC; i++) m_run[i] = 0;
  endtask

  task automatic model_edge();
    if (!reset_n) begin
      model_reset();
      return;
    end
    if (m_rs == 2) begin
      m_pr = '0;
      m_rl = '0;
      for (int i = 0; i < DC; i++) begin
        if (m_s2[i] != m_acc[i]) begin
          m_run[i]++;
          if (m_run[i] == DB + 1) begin
            m_acc[i] = ~m_acc[i];
            if (m_acc[i]) m_pr[i] = 1'b1;
            else          m_rl[i] = 1'b1;
            m_run[i] = 0;
          end
        end else begin
          m_run[i] = 0;
        end
      end
      m_s2 = m_s1;
      m_s1 = ~button_n;
    end
    if (m_rs < 2) m_rs++;
  endtask

  task automatic compare_all();
    check("reset_s2_n", reset_s2_n, (m_rs == 2));
    check("pressed", button_pressed, m_pr);
    check("released", button_released, m_rl);
    check("state", button_state, m_acc);
  endtask

  task automatic tick();
    model_edge();
    @(posedge clock);
    #1;
    compare_all();
  endtask

  task automatic set_reset(input logic v);
    reset_n = v;
    if (!v) model_reset();
    #1;
    compare_all();
  endtask

  // Runs n edges, recording first pulse edge (1-based, 0 = none) and counts for bit b.
  task automatic run_window(input int n, input int b, output int fp, output int np,
                            output int fr, output int nr);
    fp = 0; np = 0; fr = 0; nr = 0;
    for (int k = 1; k <= n; k++) begin
      tick();
      if (button_pressed[b]) begin
        np++;
        if (fp == 0) fp = k;
      end
      if (button_released[b]) begin
        nr++;
        if (fr == 0) fr = k;
      end
    end
  endtask

  initial begin
    int k, fp, np, fr, nr, bounce_pulses, bounce_level;
    int cnt_pr [DC];

    model_reset();
    #1;
    compare_all();
    repeat (5) tick();
    set_reset(1'b1);
    k = 0;
    while (!reset_s2_n && k < 10) begin
      tick();
      k++;
    end
    check("reset_release_edges", k, 2);
    check("outputs_after_reset", {button_pressed, button_released, button_state}, 0);

    // clean press then clean release on bit 0
    button_n[0] = 1'b0;
    run_window(20, 0, fp, np, fr, nr);
    check("press_edge", fp, DB + 3);
    check("press_count", np, 1);
    check("press_level", button_state[0], 1);
    button_n[0] = 1'b1;
    run_window(20, 0, fp, np, fr, nr);
    check("release_edge", fr, DB + 3);
    check("release_count", nr, 1);
    check("release_no_press", np, 0);
    check("release_level", button_state[0], 0);

    // bounce on bit 1
    bounce_pulses = 0;
    bounce_level  = 0;
    for (int j = 0; j < 26; j++) begin
      button_n[1] = (j < 16) ? (((j / 2) % 2) == 1) : 1'b1;
      tick();
      if (button_pressed[1] || button_released[1]) bounce_pulses++;
      if (button_state[1]) bounce_level++;
    end
    check("bounce_pulses", bounce_pulses, 0);
    check("bounce_level", bounce_level, 0);

    // simultaneous press of all buttons
    button_n = '0;
    for (int i = 0; i < DC; i++) cnt_pr[i] = 0;
    k = 0;
    while (button_pressed == '0 && k < 20) begin
      tick();
      k++;
    end
    check("simul_pressed", button_pressed, {DC{1'b1}});
    check("simul_edge", k, DB + 3);
    for (int i = 0; i < DC; i++) if (button_pressed[i]) cnt_pr[i]++;
    repeat (12) begin
      tick();
      for (int i = 0; i < DC; i++) if (button_pressed[i]) cnt_pr[i]++;
    end
    for (int i = 0; i < DC; i++) check("simul_count", cnt_pr[i], 1);
    button_n = '1;
    repeat (20) tick();

    // reset in the middle of a press debounce on bit 2
    button_n[2] = 1'b0;
    repeat (4) tick();
    set_reset(1'b0);
    repeat (3) begin
      tick();
      check("no_pulse_in_reset", {button_pressed, button_released}, 0);
    end
    set_reset(1'b1);
    k = 0;
    while (!reset_s2_n && k < 10) begin
      tick();
      k++;
    end
    check("mid_reset_release_edges", k, 2);
    run_window(20, 2, fp, np, fr, nr);
    check("held_through_reset_edge", fp, DB + 3);
    check("held_through_reset_count", np, 1);
    button_n[2] = 1'b1;
    repeat (20) tick();

    // random activity with occasional resets
    for (int c = 0; c < 1500; c++) begin
      for (int i = 0; i < DC; i++)
        if ($urandom_range(0, 11) == 0) button_n[i] = ~button_n[i];
      if ($urandom_range(0, 299) == 0) begin
        set_reset(1'b0);
        tick();
        tick();
        set_reset(1'b1);
      end
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
